// File: rtl/video_pkg.sv
// Shared video constants and FSM state encoding for the frame reader.
//   HDISP_DEF / VDISP_DEF : default active pixels per line / lines per frame
//   PIX_W                 : width of one framebuffer pixel word
//   fr_state_t            : frame reader FSM states
package video_pkg;

  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;
  localparam int PIX_W     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fr_state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle.
//   master : drives cyc/stb/we/adr/sel/cti/bte/dat_ms, samples dat_sm/ack/err/rty
//   slave  : the mirror image
interface wshb_if #(
  parameter int DATA_BYTES = 4
);

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, sel, cti, bte, dat_ms,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/frame_addr_gen.sv
// Pixel index and SDRAM byte address generator.
//   sys_clk, sys_rst : clock, async active-high reset
//   advance          : step to the next pixel (one pulse per accepted word)
//   p                : current pixel index, 0 .. HDISP*VDISP-1
//   adr              : BASE_ADDR + 4*p, wraps modulo 2^32
//   last_pix         : p is the final pixel of the frame
module frame_addr_gen
  import video_pkg::*;
#(
  parameter int          HDISP     = HDISP_DEF,
  parameter int          VDISP     = VDISP_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         NPIX      = HDISP * VDISP,
  localparam int         PW        = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          advance,
  output logic [PW-1:0] p,
  output logic [31:0]   adr,
  output logic          last_pix
);

  localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);

  assign last_pix = (p == P_LAST);

  // The address is kept as its own register and stepped by 4 rather than
  // derived from p, so the bus address comes straight from a flop.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p   <= '0;
      adr <= BASE_ADDR;
    end else if (advance) begin
      if (last_pix) begin
        p   <= '0;
        adr <= BASE_ADDR;
      end else begin
        p   <= p + PW'(1);
        adr <= adr + 32'd4;
      end
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Sequential framebuffer reader: fetches one 32-bit pixel word per Wishbone
// classic read and pushes it into the downstream pixel FIFO.
//   sys_clk, sys_rst : clock, async active-high reset
//   enable           : allows new reads to start
//   wshb_ifm         : Wishbone classic read master to SDRAM
//   fifo_wdata       : pixel word to FIFO
//   fifo_write       : one-cycle FIFO write strobe
//   fifo_wfull       : FIFO full, blocks new reads
//   frame_start      : pulses with the first stb cycle of the read of pixel 0
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no bus cycle; start a read when enabled and FIFO not full
// REQ   | stb/cyc held with a stable address until ack, err or rty
module frame_reader
  import video_pkg::*;
#(
  parameter int          HDISP     = HDISP_DEF,
  parameter int          VDISP     = VDISP_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         NPIX      = HDISP * VDISP,
  localparam int         PW        = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  wshb_if.master           wshb_ifm,
  output logic [PIX_W-1:0] fifo_wdata,
  output logic             fifo_write,
  input  logic             fifo_wfull,
  output logic             frame_start
);

  fr_state_t     state;
  logic          stb_q;
  logic          armed;
  logic          frame_head;
  logic          advance;
  logic          last_pix;
  logic [PW-1:0] pix_idx;
  logic [31:0]   pix_adr;

  assign advance = (state == REQ) && wshb_ifm.ack;

  frame_addr_gen #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .advance  (advance),
    .p        (pix_idx),
    .adr      (pix_adr),
    .last_pix (last_pix)
  );

  assign wshb_ifm.cyc    = stb_q;
  assign wshb_ifm.stb    = stb_q;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.adr    = pix_adr;
  assign wshb_ifm.sel    = '1;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.dat_ms = '0;

  // armed holds off the first request by one cycle after reset release.
  // frame_head marks that the next fresh read is pixel 0; it is cleared as
  // soon as that read is issued, so a retry of pixel 0 does not pulse again.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      stb_q       <= 1'b0;
      armed       <= 1'b0;
      frame_head  <= 1'b1;
      fifo_write  <= 1'b0;
      fifo_wdata  <= '0;
      frame_start <= 1'b0;
    end else begin
      armed       <= 1'b1;
      fifo_write  <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && enable && !fifo_wfull) begin
            state       <= REQ;
            stb_q       <= 1'b1;
            frame_start <= frame_head;
            frame_head  <= 1'b0;
          end
        end
        REQ: begin
          if (wshb_ifm.ack) begin
            state      <= IDLE;
            stb_q      <= 1'b0;
            fifo_write <= 1'b1;
            fifo_wdata <= wshb_ifm.dat_sm;
            frame_head <= last_pix;
          end else if (wshb_ifm.err || wshb_ifm.rty) begin
            state <= IDLE;
            stb_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          stb_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable  = 1'b0;
  logic        fifo_wfull = 1'b0;
  logic [31:0] fifo_wdata;
  logic        fifo_write;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  wshb_if #(.DATA_BYTES(4)) bus ();

  frame_reader #(
    .HDISP     (4),
    .VDISP     (2),
    .BASE_ADDR (32'h100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .enable      (enable),
    .wshb_ifm    (bus),
    .fifo_wdata  (fifo_wdata),
    .fifo_write  (fifo_write),
    .fifo_wfull  (fifo_wfull),
    .frame_start (frame_start)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave model: ack (or a one-shot rty on rty_adr) after ack_delay extra cycles.
  int          ack_delay  = 0;
  int          rty_req    = 0;
  int          rty_served = 0;
  logic [31:0] rty_adr    = 32'h0;
  int          wcnt       = 0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.ack    <= 1'b0;
      bus.err    <= 1'b0;
      bus.rty    <= 1'b0;
      bus.dat_sm <= 32'h0;
      wcnt       <= 0;
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
      bus.rty <= 1'b0;
      if (bus.stb && !bus.ack && !bus.rty) begin
        if (wcnt >= ack_delay) begin
          wcnt <= 0;
          if (rty_req != rty_served && bus.adr == rty_adr) begin
            bus.rty    <= 1'b1;
            rty_served <= rty_served + 1;
          end else begin
            bus.ack    <= 1'b1;
            bus.dat_sm <= bus.adr;
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  // Monitor, sampled on the falling edge.
  logic [31:0] wq[$];
  logic [31:0] iq[$];
  int          fs_cnt, ack_cnt, cyc_viol, stab_viol, cur_len, last_len;
  int          cyc_n, last_wr, min_gap;
  logic        stb_prev;
  logic [31:0] adr_prev;

  initial begin
    fs_cnt = 0; ack_cnt = 0; cyc_viol = 0; stab_viol = 0; cur_len = 0;
    last_len = 0; cyc_n = 0; last_wr = -1; min_gap = 1000;
    stb_prev = 1'b0; adr_prev = 32'h0;
  end

  always @(negedge sys_clk) begin
    if (bus.cyc !== bus.stb) cyc_viol++;
    if (bus.stb && !stb_prev) begin
      iq.push_back(bus.adr);
      cur_len = 0;
    end
    if (bus.stb) cur_len++;
    if (!bus.stb && stb_prev) last_len = cur_len;
    if (bus.stb && stb_prev && bus.adr !== adr_prev) stab_viol++;
    if (fifo_write) begin
      wq.push_back(fifo_wdata);
      if (last_wr >= 0 && (cyc_n - last_wr) < min_gap) min_gap = cyc_n - last_wr;
      last_wr = cyc_n;
    end
    if (frame_start) fs_cnt++;
    if (bus.ack) ack_cnt++;
    stb_prev = bus.stb;
    adr_prev = bus.adr;
    cyc_n++;
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    iq.delete();
    fs_cnt = 0; ack_cnt = 0; cyc_viol = 0; stab_viol = 0;
    last_wr = -1; min_gap = 1000; last_len = 0;
  endtask

  // Hold reset for two cycles, clear the monitor, release reset.
  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    clear_mon();
    sys_rst = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (wq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(wq.size() >= n), 32'd1);
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_stb", 32'(bus.stb), 32'd0);
    check("rst_cyc", 32'(bus.cyc), 32'd0);
    check("rst_we_sel", {27'd0, bus.we, bus.sel}, 32'h0000000F);
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_fifo_wdata", fifo_wdata, 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_adr", bus.adr, 32'h100);

    // Fill, with first-request latency after release
    enable = 1'b1;
    do_reset();
    tick();
    check("rel_edge1_stb", 32'(bus.stb), 32'd0);
    tick();
    check("rel_edge2_stb", 32'(bus.stb), 32'd1);
    check("rel_edge2_adr", bus.adr, 32'h100);
    check("rel_edge2_fs", 32'(frame_start), 32'd1);
    wait_writes(9, 60, "fill");
    for (int i = 0; i < 9; i++)
      check($sformatf("fill_w%0d", i), (i < wq.size()) ? wq[i] : 32'hDEADBEEF,
            32'h100 + 32'(4 * (i % 8)));
    check("fill_fs_cnt", 32'(fs_cnt), 32'd2);
    check("fill_min_gap", 32'(min_gap), 32'd3);
    check("fill_cyc_eq_stb", 32'(cyc_viol), 32'd0);

    // Backpressure from reset
    fifo_wfull = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("bp_no_stb", 32'(iq.size()), 32'd0);
    fifo_wfull = 1'b0;
    tick();
    check("bp_release_stb", 32'(bus.stb), 32'd1);
    check("bp_release_adr", bus.adr, 32'h100);
    check("bp_release_fs", 32'(frame_start), 32'd1);

    // Retry on 0x108
    rty_adr = 32'h108;
    rty_req = rty_req + 1;
    do_reset();
    wait_writes(9, 80, "rty");
    for (int i = 0; i < 9; i++)
      check($sformatf("rty_w%0d", i), (i < wq.size()) ? wq[i] : 32'hDEADBEEF,
            32'h100 + 32'(4 * (i % 8)));
    check("rty_iss2", (iq.size() > 3) ? iq[2] : 32'hDEADBEEF, 32'h108);
    check("rty_iss3", (iq.size() > 3) ? iq[3] : 32'hDEADBEEF, 32'h108);
    check("rty_iss4", (iq.size() > 4) ? iq[4] : 32'hDEADBEEF, 32'h10C);
    check("rty_fs_cnt", 32'(fs_cnt), 32'd2);
    check("rty_served", 32'(rty_served), 32'd1);

    // Wait states
    ack_delay = 5;
    do_reset();
    wait_writes(3, 60, "ws");
    check("ws_w0", (wq.size() > 0) ? wq[0] : 32'hDEADBEEF, 32'h100);
    check("ws_w1", (wq.size() > 1) ? wq[1] : 32'hDEADBEEF, 32'h104);
    check("ws_w2", (wq.size() > 2) ? wq[2] : 32'hDEADBEEF, 32'h108);
    check("ws_stable", 32'(stab_viol), 32'd0);
    check("ws_stb_len", 32'(last_len), 32'd7);
    check("ws_acks_eq_writes", 32'(ack_cnt), 32'(wq.size()));

    // Reset mid-transfer at 0x10C
    ack_delay = 0;
    do_reset();
    begin
      int k;
      k = 0;
      while (!(bus.stb && bus.adr == 32'h10C) && k < 40) begin
        tick();
        k++;
      end
      check("mid_reach_10c", 32'(bus.stb && bus.adr == 32'h10C), 32'd1);
    end
    check("mid_writes_before", 32'(wq.size()), 32'd3);
    sys_rst = 1'b1;
    #1;
    check("mid_stb_drop", 32'(bus.stb), 32'd0);
    check("mid_cyc_drop", 32'(bus.cyc), 32'd0);
    check("mid_fw_drop", 32'(fifo_write), 32'd0);
    tick();
    clear_mon();
    sys_rst = 1'b0;
    tick();
    tick();
    check("mid_restart_adr", (iq.size() > 0) ? iq[0] : 32'hDEADBEEF, 32'h100);
    check("mid_restart_fs", 32'(fs_cnt), 32'd1);

    // Enable dropped while in REQ
    ack_delay = 3;
    do_reset();
    begin
      int k;
      k = 0;
      while (!bus.stb && k < 10) begin
        tick();
        k++;
      end
      check("en_stb_seen", 32'(bus.stb), 32'd1);
    end
    enable = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("en_one_write", 32'(wq.size()), 32'd1);
    check("en_write_val", (wq.size() > 0) ? wq[0] : 32'hDEADBEEF, 32'h100);
    check("en_no_new_stb", 32'(iq.size()), 32'd1);
    enable = 1'b1;
    wait_writes(2, 30, "en_resume");
    check("en_resume_val", (wq.size() > 1) ? wq[1] : 32'hDEADBEEF, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
